// File: rtl/prga.sv
// ARC4 pseudo-random generation stage: walks the scheduled S-box, swaps entries and
// XORs the keystream with the length-prefixed ciphertext to produce the plaintext.
//
// state  | meaning
// IDLE   | rdy high, waiting for en
// RD_LEN | ciphertext length byte addressed
// WR_LEN | length copied to PT[0]; stop here if it is zero
// RD_SI  | S[i+1] addressed, i advances
// RD_SJ  | S[i] arrives, j advances, S[j] addressed
// SW_I   | S[j] arrives and is written to S[i]
// SW_J   | old S[i] written to S[j]
// RD_PAD | keystream byte S[si+sj] and CT[k] addressed
// WR_PT  | PT[k] written; loop or finish
// DONE   | one dead cycle before returning to IDLE
module prga (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       en_i,
    output logic       rdy_o,
    output logic [7:0] s_addr_o,
    input  logic [7:0] s_rddata_i,
    output logic [7:0] s_wrdata_o,
    output logic       s_wren_o,
    output logic [7:0] ct_addr_o,
    input  logic [7:0] ct_rddata_i,
    output logic [7:0] pt_addr_o,
    output logic [7:0] pt_wrdata_o,
    output logic       pt_wren_o
);

    typedef enum logic [3:0] {
        IDLE,
        RD_LEN,
        WR_LEN,
        RD_SI,
        RD_SJ,
        SW_I,
        SW_J,
        RD_PAD,
        WR_PT,
        DONE
    } state_t;

    state_t     state_q;
    logic [7:0] i_q, j_q, k_q, len_q;
    logic [7:0] si_q, sj_q;
    logic       rdy_q;
    logic       s_wren_q, pt_wren_q;
    logic [7:0] s_addr_q, s_wdat_q, ct_addr_q, pt_addr_q;

    logic [7:0] i_d, j_d, k_d, pad_addr_d;

    assign i_d        = i_q + 8'd1;
    assign j_d        = j_q + s_rddata_i;
    assign k_d        = k_q + 8'd1;
    assign pad_addr_d = si_q + sj_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            rdy_q     <= 1'b1;
            i_q       <= 8'd0;
            j_q       <= 8'd0;
            k_q       <= 8'd0;
            len_q     <= 8'd0;
            si_q      <= 8'd0;
            sj_q      <= 8'd0;
            s_wren_q  <= 1'b0;
            pt_wren_q <= 1'b0;
            s_addr_q  <= 8'd0;
            s_wdat_q  <= 8'd0;
            ct_addr_q <= 8'd0;
            pt_addr_q <= 8'd0;
        end else begin
            s_wren_q  <= 1'b0;
            pt_wren_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en_i) begin
                        state_q   <= RD_LEN;
                        rdy_q     <= 1'b0;
                        i_q       <= 8'd0;
                        j_q       <= 8'd0;
                        k_q       <= 8'd0;
                        ct_addr_q <= 8'd0;
                    end
                end
                RD_LEN: begin
                    state_q   <= WR_LEN;
                    pt_addr_q <= 8'd0;
                    pt_wren_q <= 1'b1;
                end
                WR_LEN: begin
                    len_q <= ct_rddata_i;
                    if (ct_rddata_i == 8'd0) begin
                        state_q <= DONE;
                    end else begin
                        k_q      <= 8'd1;
                        s_addr_q <= i_d;
                        state_q  <= RD_SI;
                    end
                end
                RD_SI: begin
                    i_q     <= i_d;
                    state_q <= RD_SJ;
                end
                // i_q already holds the advanced index here, so SW_I can address it directly
                RD_SJ: begin
                    si_q     <= s_rddata_i;
                    j_q      <= j_d;
                    s_addr_q <= i_q;
                    s_wren_q <= 1'b1;
                    state_q  <= SW_I;
                end
                SW_I: begin
                    sj_q     <= s_rddata_i;
                    s_addr_q <= j_q;
                    s_wdat_q <= si_q;
                    s_wren_q <= 1'b1;
                    state_q  <= SW_J;
                end
                SW_J: begin
                    s_addr_q  <= pad_addr_d;
                    ct_addr_q <= k_q;
                    state_q   <= RD_PAD;
                end
                RD_PAD: begin
                    pt_addr_q <= k_q;
                    pt_wren_q <= 1'b1;
                    state_q   <= WR_PT;
                end
                WR_PT: begin
                    if (k_q == len_q) begin
                        state_q <= DONE;
                    end else begin
                        k_q      <= k_d;
                        s_addr_q <= i_d;
                        state_q  <= RD_SI;
                    end
                end
                DONE: begin
                    rdy_q   <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    rdy_q   <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Read data is only valid in the cycle that consumes it, so these paths bypass the registers.
    assign s_addr_o    = (state_q == RD_SJ) ? j_d : s_addr_q;
    assign s_wrdata_o  = (state_q == SW_I) ? s_rddata_i : s_wdat_q;
    assign pt_wrdata_o = (state_q == WR_PT) ? (s_rddata_i ^ ct_rddata_i) : ct_rddata_i;

    assign rdy_o     = rdy_q;
    assign s_wren_o  = s_wren_q;
    assign pt_wren_o = pt_wren_q;
    assign ct_addr_o = ct_addr_q;
    assign pt_addr_o = pt_addr_q;

endmodule

// File: tb/tb_prga.sv
// Bench for prga: behavioural synchronous memories, software ARC4 reference and a PT-write scoreboard.
module tb_prga;

    logic       clk = 1'b0;
    logic       rst_n, en, rdy;
    logic [7:0] s_addr, s_rddata, s_wrdata, ct_addr, ct_rddata, pt_addr, pt_wrdata;
    logic       s_wren, pt_wren;

    always #5 clk = ~clk;

    prga dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .en_i        (en),
        .rdy_o       (rdy),
        .s_addr_o    (s_addr),
        .s_rddata_i  (s_rddata),
        .s_wrdata_o  (s_wrdata),
        .s_wren_o    (s_wren),
        .ct_addr_o   (ct_addr),
        .ct_rddata_i (ct_rddata),
        .pt_addr_o   (pt_addr),
        .pt_wrdata_o (pt_wrdata),
        .pt_wren_o   (pt_wren)
    );

    logic [7:0] s_mem [256];
    logic [7:0] ct_mem[256];
    logic [7:0] pt_mem[256];
    logic [7:0] s_img [256];
    logic [7:0] ct_img[256];
    logic [7:0] exp_s [256];
    logic [7:0] s_rd_q, ct_rd_q;
    logic       load_req = 1'b0;

    assign s_rddata  = s_rd_q;
    assign ct_rddata = ct_rd_q;

    always @(posedge clk) begin
        s_rd_q  <= s_mem[s_addr];
        ct_rd_q <= ct_mem[ct_addr];
        if (load_req) begin
            for (int a = 0; a < 256; a++) begin
                s_mem[a]  <= s_img[a];
                ct_mem[a] <= ct_img[a];
                pt_mem[a] <= 8'hEE;
            end
        end else begin
            if (s_wren)  s_mem[s_addr]   <= s_wrdata;
            if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int s_wr_cnt = 0;
    bit sb_en = 1'b1;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (s_wren) s_wr_cnt++;
        if (s_wren && pt_wren) begin
            n_bad++;
            $display("FAIL wren_onehot: s_wren and pt_wren both high at %0t", $time);
        end
        if (sb_en && pt_wren) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pt_write: unexpected write addr 0x%0h data 0x%0h", pt_addr, pt_wrdata);
            end else begin
                e = exp_q.pop_front();
                check("pt_write", 32'({pt_addr, pt_wrdata}), 32'({e.a, e.d}));
            end
        end
    end

    task automatic make_identity();
        for (int a = 0; a < 256; a++) s_img[a] = 8'(a);
    endtask

    task automatic make_ksa(input logic [7:0] key0);
        logic [7:0] key[3];
        logic [7:0] j, t;
        key[0] = key0;
        key[1] = 8'h5A;
        key[2] = 8'hC3;
        make_identity();
        j = 8'd0;
        for (int a = 0; a < 256; a++) begin
            j = 8'(j + s_img[a] + key[a % 3]);
            t = s_img[a];
            s_img[a] = s_img[j];
            s_img[j] = t;
        end
    endtask

    // Reference ARC4 keystream over the loaded images; pushes every expected PT write.
    task automatic predict();
        logic [7:0] sm[256];
        logic [7:0] i, j, t, pad;
        int len;
        sm  = s_img;
        len = int'(ct_img[0]);
        exp_q.push_back('{a: 8'd0, d: ct_img[0]});
        i = 8'd0;
        j = 8'd0;
        for (int k = 1; k <= len; k++) begin
            i = 8'(i + 8'd1);
            j = 8'(j + sm[i]);
            t = sm[i];
            sm[i] = sm[j];
            sm[j] = t;
            pad = sm[8'(sm[i] + sm[j])];
            exp_q.push_back('{a: 8'(k), d: ct_img[k] ^ pad});
        end
        exp_s = sm;
    endtask

    task automatic load_mems();
        @(negedge clk);
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
    endtask

    task automatic start_and_wait(input string name, input int exp_cycles, input bit poke);
        int n;
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        check({name, "_busy_E0"}, 32'(rdy), 32'd0);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            en = poke && (n == 4);
        end while (!rdy && n < 5000);
        en = 1'b0;
        check({name, "_rdy_edge"}, 32'(n), 32'(exp_cycles));
    endtask

    task automatic check_s(input string name);
        int diffs;
        diffs = 0;
        for (int a = 0; a < 256; a++) if (s_mem[a] !== exp_s[a]) diffs++;
        check({name, "_s_final_diffs"}, 32'(diffs), 32'd0);
    endtask

    typedef struct {
        int         len;
        bit         ksa;
        logic [7:0] key0;
        logic [7:0] ct1;
        logic [7:0] ct2;
        bit         fixed;
        logic [7:0] exp1;
        logic [7:0] exp2;
        logic [7:0] exp_s2;
        logic [7:0] exp_s3;
        int         cycles;
        bit         poke;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{0,   1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'hEE, 8'hEE, 8'h02, 8'h03, 3,    1'b0};
        vecs[1] = '{1,   1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'h02, 8'hEE, 8'h02, 8'h03, 9,    1'b0};
        vecs[2] = '{2,   1'b0, 8'h00, 8'hFF, 8'h00, 1'b1, 8'hFD, 8'h05, 8'h03, 8'h02, 15,   1'b0};
        vecs[3] = '{16,  1'b1, 8'h3C, 8'h12, 8'h34, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 99,   1'b1};
        vecs[4] = '{255, 1'b1, 8'hA5, 8'h9E, 8'h01, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1533, 1'b1};
        vecs[5] = '{7,   1'b0, 8'h00, 8'h55, 8'hAA, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 45,   1'b0};

        rst_n = 1'b0;
        en    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy",     32'(rdy), 32'd1);
        check("rst_wrens",   32'({s_wren, pt_wren}), 32'd0);
        check("rst_s_addr",  32'(s_addr), 32'd0);
        check("rst_ct_addr", 32'(ct_addr), 32'd0);
        check("rst_pt_addr", 32'(pt_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].ksa) make_ksa(vecs[v].key0);
            else make_identity();
            for (int a = 0; a < 256; a++) ct_img[a] = 8'($urandom_range(0, 255));
            ct_img[0] = 8'(vecs[v].len);
            ct_img[1] = vecs[v].ct1;
            ct_img[2] = vecs[v].ct2;
            load_mems();
            predict();
            s_wr_cnt = 0;
            start_and_wait($sformatf("vec%0d", v), vecs[v].cycles, vecs[v].poke);
            check($sformatf("vec%0d_sb_drained", v), 32'(exp_q.size()), 32'd0);
            check($sformatf("vec%0d_s_writes", v), 32'(s_wr_cnt), 32'(2 * vecs[v].len));
            check_s($sformatf("vec%0d", v));
            if (vecs[v].fixed) begin
                check($sformatf("vec%0d_pt0", v), 32'(pt_mem[0]), 32'(vecs[v].len));
                check($sformatf("vec%0d_pt1", v), 32'(pt_mem[1]), 32'(vecs[v].exp1));
                check($sformatf("vec%0d_pt2", v), 32'(pt_mem[2]), 32'(vecs[v].exp2));
                check($sformatf("vec%0d_s2", v),  32'(s_mem[2]),  32'(vecs[v].exp_s2));
                check($sformatf("vec%0d_s3", v),  32'(s_mem[3]),  32'(vecs[v].exp_s3));
            end
        end

        // en held high across completion restarts immediately after the single idle cycle
        make_identity();
        for (int a = 0; a < 256; a++) ct_img[a] = 8'h00;
        load_mems();
        predict();
        predict();
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1 check("hold_busy_E0", 32'(rdy), 32'd0);
        repeat (3) @(posedge clk);
        #1 check("hold_rdy_E3", 32'(rdy), 32'd1);
        @(posedge clk);
        #1 check("hold_restart_E4", 32'(rdy), 32'd0);
        en = 1'b0;
        begin
            int n;
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (!rdy && n < 50);
            check("hold_second_run_edges", 32'(n), 32'd3);
        end
        check("hold_sb_drained", 32'(exp_q.size()), 32'd0);

        // abort mid-message with reset, then re-run from a fresh identity S
        make_identity();
        for (int a = 0; a < 256; a++) ct_img[a] = 8'($urandom_range(0, 255));
        ct_img[0] = 8'h10;
        load_mems();
        sb_en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_rdy",     32'(rdy), 32'd1);
        check("abort_wrens",   32'({s_wren, pt_wren}), 32'd0);
        check("abort_s_addr",  32'(s_addr), 32'd0);
        check("abort_ct_addr", 32'(ct_addr), 32'd0);
        check("abort_pt_addr", 32'(pt_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        sb_en = 1'b1;
        load_mems();
        predict();
        start_and_wait("rerun", 99, 1'b1);
        check("rerun_sb_drained", 32'(exp_q.size()), 32'd0);
        check_s("rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
